mem_bus_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_size_mask.sv | 23 ++
 rtl/mem_bus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory bus arbiter: FSM states, access
// size codes, one-hot grant codes and the wait-counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    // Grant codes are one-hot {dma, cpu}.
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_CPU  = 2'b01;
    localparam logic [1:0] GNT_DMA  = 2'b10;

    // Wide enough for WAIT_CYCLES-1 with WAIT_CYCLES up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_size_mask.sv
// Zero-extends bus read data to the access size: byte, half, word or the
// full double.
module mem_size_mask
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [1:0]        size_i,
    output logic [DATA_W-1:0] data_o
);

    always_comb begin
        data_o = '0;
        case (size_i)
            SZ_B:    data_o[7:0]  = data_i[7:0];
            SZ_H:    data_o[15:0] = data_i[15:0];
            SZ_W:    data_o[31:0] = data_i[31:0];
            default: data_o       = data_i;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester (cpu/dma) arbiter for the shared memory bus: IDLE -> ACCESS
// for WAIT_CYCLES cycles -> DONE (one-cycle ack). Define ARB_ROUND_ROBIN_EN
// for round-robin tie breaking; otherwise the CPU always wins ties.
//
// Handshake: a requester raises req with we/addr/wdata/size stable and holds
// it until its ack pulses for one cycle; the access is committed on the IDLE
// edge that samples req, so dropping req afterwards neither aborts it nor
// suppresses the ack. rdata is valid during ack and holds until the next
// access by the same requester.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [1:0]        cpu_size,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic [1:0]        dma_size,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_select,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_size,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        grant_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        size_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;
    logic [DATA_W-1:0] masked_rdata;
    logic [DATA_W-1:0] load_data;
    logic              any_req;
    logic              pick_dma;
    logic              last_access;

    assign any_req     = cpu_req | dma_req;
    assign last_access = (state_q == ACCESS) && (cnt_q == '0);

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] last_grant_q;

    // On a tie the requester that did not win last time goes first.
    assign pick_dma = dma_req & (~cpu_req | (last_grant_q == GNT_CPU));
`else
    assign pick_dma = dma_req & ~cpu_req;
`endif

    mem_size_mask #(.DATA_W(DATA_W)) u_size_mask (
        .data_i (mem_rdata),
        .size_i (size_q),
        .data_o (masked_rdata)
    );

    // Stores complete with zero read data.
    assign load_data = we_q ? '0 : masked_rdata;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                end
            end
            ACCESS: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_q     <= GNT_NONE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= SZ_B;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= GNT_DMA;
`endif
        end else begin
            if (state_q == IDLE && any_req) begin
                grant_q <= pick_dma ? GNT_DMA   : GNT_CPU;
                we_q    <= pick_dma ? dma_we    : cpu_we;
                addr_q  <= pick_dma ? dma_addr  : cpu_addr;
                wdata_q <= pick_dma ? dma_wdata : cpu_wdata;
                size_q  <= pick_dma ? dma_size  : cpu_size;
`ifdef ARB_ROUND_ROBIN_EN
                last_grant_q <= pick_dma ? GNT_DMA : GNT_CPU;
`endif
            end
            if (last_access) begin
                if (grant_q == GNT_DMA) dma_rdata_q <= load_data;
                else                    cpu_rdata_q <= load_data;
            end
            if (state_q == DONE) grant_q <= GNT_NONE;
        end
    end

    // Bus outputs are forced to zero outside ACCESS so an idle bus is quiet.
    always_comb begin
        mem_select   = (state_q == ACCESS);
        mem_write_en = 1'b0;
        mem_address  = '0;
        mem_wdata    = '0;
        mem_size     = SZ_B;
        if (mem_select) begin
            mem_write_en = we_q;
            mem_address  = addr_q;
            mem_wdata    = wdata_q;
            mem_size     = size_q;
        end
        cpu_ack   = (state_q == DONE) && (grant_q == GNT_CPU);
        dma_ack   = (state_q == DONE) && (grant_q == GNT_DMA);
        cpu_rdata = cpu_rdata_q;
        dma_rdata = dma_rdata_q;
        grant     = grant_q;
        busy      = (state_q != IDLE);
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_mem_bus_arbiter;

    localparam int W = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 0, cpu_we = 0;
    logic [31:0] cpu_addr = '0;
    logic [63:0] cpu_wdata = '0;
    logic [1:0]  cpu_size = '0;
    logic        cpu_ack;
    logic [63:0] cpu_rdata;
    logic        dma_req = 0, dma_we = 0;
    logic [31:0] dma_addr = '0;
    logic [63:0] dma_wdata = '0;
    logic [1:0]  dma_size = '0;
    logic        dma_ack;
    logic [63:0] dma_rdata;
    logic        mem_select, mem_write_en;
    logic [31:0] mem_address;
    logic [63:0] mem_wdata;
    logic [1:0]  mem_size;
    logic [63:0] mem_rdata = '0;
    logic [1:0]  grant;
    logic        busy;
    logic [1:0]  state_dbg;

    int n_chk = 0;
    int n_err = 0;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(64), .WAIT_CYCLES(W)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_size(cpu_size), .cpu_ack(cpu_ack),
        .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_size(dma_size), .dma_ack(dma_ack),
        .dma_rdata(dma_rdata),
        .mem_select(mem_select), .mem_write_en(mem_write_en),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_rdata(mem_rdata), .grant(grant), .busy(busy), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_phase: 0 = bus free, 1..W = bus cycles of the access, W+1 = ack cycle.
    int          m_phase;
    bit          m_owner_dma;
    logic        m_we;
    logic [31:0] m_addr;
    logic [63:0] m_wdata;
    logic [1:0]  m_size;
    logic [63:0] m_cpu_rd, m_dma_rd;
    logic        m_pick_dma;

    function automatic logic [63:0] zext(input logic [63:0] d, input logic [1:0] s);
        int nbits;
        nbits = 8 << s;
        if (nbits >= 64) return d;
        return d & ((64'd1 << nbits) - 64'd1);
    endfunction

`ifdef ARB_ROUND_ROBIN_EN
    bit m_last_dma;
    assign m_pick_dma = dma_req && (!cpu_req || !m_last_dma);
`else
    assign m_pick_dma = dma_req && !cpu_req;
`endif

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_phase <= 0; m_owner_dma <= 0; m_we <= 0; m_addr <= '0;
            m_wdata <= '0; m_size <= '0; m_cpu_rd <= '0; m_dma_rd <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            m_last_dma <= 1'b1;
`endif
        end else if (m_phase == 0) begin
            if (cpu_req || dma_req) begin
                m_phase     <= 1;
                m_owner_dma <= m_pick_dma;
                m_we        <= m_pick_dma ? dma_we    : cpu_we;
                m_addr      <= m_pick_dma ? dma_addr  : cpu_addr;
                m_wdata     <= m_pick_dma ? dma_wdata : cpu_wdata;
                m_size      <= m_pick_dma ? dma_size  : cpu_size;
`ifdef ARB_ROUND_ROBIN_EN
                m_last_dma  <= m_pick_dma;
`endif
            end
        end else if (m_phase < W) begin
            m_phase <= m_phase + 1;
        end else if (m_phase == W) begin
            if (m_owner_dma) m_dma_rd <= m_we ? 64'd0 : zext(mem_rdata, m_size);
            else             m_cpu_rd <= m_we ? 64'd0 : zext(mem_rdata, m_size);
            m_phase <= W + 1;
        end else begin
            m_phase <= 0;
        end
    end

    function automatic bit m_bus();   return m_phase >= 1 && m_phase <= W; endfunction
    function automatic bit m_ack_cpu(); return m_phase == W + 1 && !m_owner_dma; endfunction
    function automatic bit m_ack_dma(); return m_phase == W + 1 && m_owner_dma; endfunction

    // ---------------- compare process and monitors ----------------
    int          sel_cycles = 0, wr_cycles = 0, cpu_acks = 0, dma_acks = 0;
    logic [31:0] seen_addr = '0;

    always @(negedge clock) begin
        check("mem_select",   mem_select,   m_bus());
        check("mem_write_en", mem_write_en, m_bus() && m_we);
        check("mem_address",  mem_address,  m_bus() ? m_addr  : 32'd0);
        check("mem_wdata",    mem_wdata,    m_bus() ? m_wdata : 64'd0);
        check("mem_size",     mem_size,     m_bus() ? m_size  : 2'd0);
        check("grant",        grant,        m_phase == 0 ? 2'b00 : (m_owner_dma ? 2'b10 : 2'b01));
        check("busy",         busy,         m_phase != 0);
        check("cpu_ack",      cpu_ack,      m_ack_cpu());
        check("dma_ack",      dma_ack,      m_ack_dma());
        check("cpu_rdata",    cpu_rdata,    m_cpu_rd);
        check("dma_rdata",    dma_rdata,    m_dma_rd);
        if (mem_select) begin sel_cycles++; seen_addr = mem_address; end
        if (mem_write_en) wr_cycles++;
        if (cpu_ack) cpu_acks++;
        if (dma_ack) dma_acks++;
    end

    // ---------------- driver tasks ----------------
    task automatic clear_mon();
        sel_cycles = 0; wr_cycles = 0; cpu_acks = 0; dma_acks = 0;
    endtask

    task automatic wait_ack(input bit dma);
        bit ok;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clock);
            if (dma ? dma_ack : cpu_ack) ok = 1;
        end
        if (!ok) check("ack_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_access(input bit dma, input bit we, input logic [31:0] addr,
                             input logic [63:0] wd, input logic [1:0] sz, input logic [63:0] rd);
        @(negedge clock);
        mem_rdata = rd;
        if (dma) begin dma_req = 1; dma_we = we; dma_addr = addr; dma_wdata = wd; dma_size = sz; end
        else     begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_size = sz; end
        wait_ack(dma);
        if (dma) dma_req = 0; else cpu_req = 0;
        repeat (3) @(negedge clock);
    endtask

    task automatic rand_fields(input bit dma);
        if (dma) begin
            dma_we = 1'($urandom_range(0, 1)); dma_addr = $urandom;
            dma_wdata = {$urandom, $urandom}; dma_size = 2'($urandom_range(0, 3));
        end else begin
            cpu_we = 1'($urandom_range(0, 1)); cpu_addr = $urandom;
            cpu_wdata = {$urandom, $urandom}; cpu_size = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic drive_rand();
        mem_rdata = {$urandom, $urandom};
        if (cpu_req && m_ack_cpu()) begin
            if ($urandom_range(0, 2) == 0) rand_fields(0); else cpu_req = 0;
        end else if (cpu_req && m_bus() && !m_owner_dma && $urandom_range(0, 7) == 0) begin
            cpu_req = 0;
        end else if (!cpu_req && $urandom_range(0, 2) == 0) begin
            cpu_req = 1; rand_fields(0);
        end
        if (dma_req && m_ack_dma()) begin
            if ($urandom_range(0, 2) == 0) rand_fields(1); else dma_req = 0;
        end else if (dma_req && m_bus() && m_owner_dma && $urandom_range(0, 7) == 0) begin
            dma_req = 0;
        end else if (!dma_req && $urandom_range(0, 2) == 0) begin
            dma_req = 1; rand_fields(1);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0]  order;
        logic [63:0] x;
        repeat (3) @(negedge clock);
        check("rst_select", mem_select, 1'b0);
        check("rst_grant",  grant,      2'b00);
        check("rst_busy",   busy,       1'b0);
        check("rst_rdata",  cpu_rdata,  64'd0);
        reset = 0;
        repeat (2) @(negedge clock);

        // CPU double load alone
        clear_mon();
        do_access(0, 0, 32'h40, 64'd0, 2'b11, 64'hDEAD_BEEF_0123_4567);
        check("t1_rdata",  cpu_rdata,  64'hDEAD_BEEF_0123_4567);
        check("t1_sel",    sel_cycles, 2);
        check("t1_acks",   cpu_acks,   1);
        check("t1_wr",     wr_cycles,  0);

        // size masking on loads
        do_access(0, 0, 32'h44, 64'd0, 2'b01, 64'hFFFF_FFFF_FFFF_8001);
        check("t4_half", cpu_rdata, 64'h8001);
        do_access(0, 0, 32'h48, 64'd0, 2'b10, 64'hFFFF_FFFF_FFFF_8001);
        check("t4_word", cpu_rdata, 64'hFFFF_8001);

        // DMA byte store
        clear_mon();
        do_access(1, 1, 32'h100, 64'hAA, 2'b00, 64'h1234_5678_9ABC_DEF0);
        check("t2_rdata", dma_rdata, 64'd0);
        check("t2_wr",    wr_cycles, 2);
        check("t2_addr",  seen_addr, 32'h100);
        check("t2_dack",  dma_acks,  1);
        check("t2_cack",  cpu_acks,  0);

        // simultaneous requests held for three rounds
        @(negedge clock);
        cpu_req = 1; cpu_we = 0; cpu_size = 2'b11; cpu_addr = 32'h200;
        dma_req = 1; dma_we = 0; dma_size = 2'b11; dma_addr = 32'h300;
        order = '0;
        for (int k = 0; k < 3; k++) begin
            bit ok;
            ok = 0;
            for (int i = 0; i < 40 && !ok; i++) begin
                @(negedge clock);
                if (cpu_ack || dma_ack) begin ok = 1; order[k] = dma_ack; end
            end
            if (!ok) check("t3_timeout", 64'd0, 64'd1);
        end
        cpu_req = 0; dma_req = 0;
`ifdef ARB_ROUND_ROBIN_EN
        check("t3_order", order, 3'b010);
`else
        check("t3_order", order, 3'b000);
`endif
        repeat (3) @(negedge clock);

        // reset in the second bus cycle
        clear_mon();
        cpu_req = 1; cpu_we = 0; cpu_size = 2'b11; cpu_addr = 32'h500;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        #1 reset = 1;
        @(negedge clock);
        check("t5_sel",   mem_select, 1'b0);
        check("t5_grant", grant,      2'b00);
        check("t5_ack",   cpu_acks,   0);
        cpu_req = 0;
        reset = 0;
        do_access(0, 0, 32'h508, 64'd0, 2'b10, 64'h0BAD_F00D_CAFE_1234);
        check("t5_after", cpu_rdata, 64'hCAFE_1234);

        // request dropped mid-access
        clear_mon();
        x = 64'h1122_3344_5566_7788;
        mem_rdata = x;
        cpu_req = 1; cpu_we = 0; cpu_size = 2'b11; cpu_addr = 32'h600;
        @(posedge clock);
        @(negedge clock);
        cpu_req = 0;
        repeat (6) @(negedge clock);
        check("t6_acks",  cpu_acks,  1);
        check("t6_busy",  busy,      1'b0);
        check("t6_rdata", cpu_rdata, x);

        // randomized traffic with occasional resets
        for (int c = 0; c < 2000; c++) begin
            @(negedge clock);
            if (reset) reset = 0;
            drive_rand();
            if ($urandom_range(0, 299) == 0) #2 reset = 1;
        end
        @(negedge clock);
        reset = 0; cpu_req = 0; dma_req = 0;
        repeat (8) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
